// File: rtl/ysyx_25040111_mem_bus_sched.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_mem_bus_sched
// Shares one downstream memory port between the I-cache refill master (IFU,
// burst reads) and the LSU (single-beat reads and writes).
//
// The arbiter is round-robin. A grant is held for a whole transaction,
// including every beat of an IFU burst. Response beats go straight through
// to the owning master with no buffering.
//
// Ports
//   clock, reset            : system clock, synchronous active-high reset
//   ifu_ar*, ifu_r*         : IFU read request / response handshake
//   lsu_ar*, lsu_r*         : LSU read request / response handshake
//   lsu_w*, lsu_bvalid      : LSU write request / response handshake
//   rsp_data, rsp_err       : response data and error, shared by both masters
//   mem_ar*, mem_r*         : downstream read address / data channel
//   mem_w*, mem_b*          : downstream write request / response channel
// ---------------------------------------------------------------------------
module ysyx_25040111_mem_bus_sched #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_arvalid,
  input  logic [AW-1:0]   ifu_araddr,
  input  logic [7:0]      ifu_arlen,
  output logic            ifu_arready,
  output logic            ifu_rvalid,
  output logic            ifu_rlast,
  input  logic            lsu_arvalid,
  input  logic [AW-1:0]   lsu_araddr,
  input  logic [1:0]      lsu_arsize,
  output logic            lsu_arready,
  output logic            lsu_rvalid,
  input  logic            lsu_wvalid,
  input  logic [AW-1:0]   lsu_waddr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_wready,
  output logic            lsu_bvalid,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            mem_arvalid,
  input  logic            mem_arready,
  output logic [AW-1:0]   mem_araddr,
  output logic [7:0]      mem_arlen,
  output logic [1:0]      mem_arsize,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rlast,
  input  logic            mem_rerr,
  output logic            mem_wvalid,
  input  logic            mem_wready,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_bvalid,
  input  logic            mem_berr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRSP  = 3'd4
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  logic ifu_req;
  logic lsu_req;
  logic grant_ifu;
  logic grant_lsu;
  logic burst_done;

  // IFU wins whenever the LSU is idle or the LSU was served last.
  assign ifu_req    = ifu_arvalid;
  assign lsu_req    = lsu_arvalid | lsu_wvalid;
  assign grant_ifu  = ifu_req & (~lsu_req | (last_grant_q == OWN_LSU));
  assign grant_lsu  = lsu_req & ~grant_ifu;
  assign burst_done = (beat_cnt_q == len_q);

  // The read and write channels share the latched address register.
  assign mem_araddr = addr_q;
  assign mem_arlen  = len_q;
  assign mem_arsize = size_q;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

  // Next-state, request latching and combinational handshake/forwarding.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    beat_cnt_d   = beat_cnt_q;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rlast    = 1'b0;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_wready   = 1'b0;
    lsu_bvalid   = 1'b0;
    rsp_data     = {DW{1'b0}};
    rsp_err      = 1'b0;
    mem_arvalid  = 1'b0;
    mem_wvalid   = 1'b0;

    if (reset) begin
      // Hold every output low while reset is asserted, even mid-transaction.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ifu) begin
            ifu_arready  = 1'b1;
            addr_d       = ifu_araddr;
            len_d        = ifu_arlen;
            size_d       = 2'd2;
            owner_d      = OWN_IFU;
            last_grant_d = OWN_IFU;
            state_d      = RADDR;
          end else if (grant_lsu) begin
            owner_d      = OWN_LSU;
            last_grant_d = OWN_LSU;
            // A simultaneous LSU write takes precedence over its read.
            if (lsu_wvalid) begin
              lsu_wready = 1'b1;
              addr_d     = lsu_waddr;
              wdata_d    = lsu_wdata;
              wstrb_d    = lsu_wstrb;
              state_d    = WREQ;
            end else begin
              lsu_arready = 1'b1;
              addr_d      = lsu_araddr;
              len_d       = 8'd0;
              size_d      = lsu_arsize;
              state_d     = RADDR;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RADDR: begin
          mem_arvalid = 1'b1;
          if (mem_arready) begin
            beat_cnt_d = 8'd0;
            state_d    = RDATA;
          end else begin
            state_d = RADDR;
          end
        end
        RDATA: begin
          if (mem_rvalid) begin
            ifu_rvalid = (owner_q == OWN_IFU);
            lsu_rvalid = (owner_q == OWN_LSU);
            rsp_data   = mem_rdata;
            // The beat count, not mem_rlast, ends the burst; a disagreeing
            // rlast is reported as an error on that beat.
            rsp_err    = mem_rerr | (mem_rlast ^ burst_done);
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (burst_done) begin
              ifu_rlast = (owner_q == OWN_IFU);
              state_d   = IDLE;
            end else begin
              state_d = RDATA;
            end
          end else begin
            state_d = RDATA;
          end
        end
        WREQ: begin
          mem_wvalid = 1'b1;
          if (mem_wready) begin
            state_d = WRSP;
          end else begin
            state_d = WREQ;
          end
        end
        WRSP: begin
          if (mem_bvalid) begin
            lsu_bvalid = 1'b1;
            rsp_err    = mem_berr;
            state_d    = IDLE;
          end else begin
            state_d = WRSP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and transaction registers; last_grant resets to LSU so IFU wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_LSU;
      addr_q       <= {AW{1'b0}};
      len_q        <= 8'd0;
      size_q       <= 2'd0;
      wdata_q      <= {DW{1'b0}};
      wstrb_q      <= {(DW/8){1'b0}};
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_bus_sched.sv
`timescale 1ns/1ps
// Self-checking bench for ysyx_25040111_mem_bus_sched. It plays the downstream
// memory itself and checks grants, latched fields and forwarded beats against
// expectations computed from the requests it issues.
module tb_ysyx_25040111_mem_bus_sched;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast;
  logic [AW-1:0]   ifu_araddr;
  logic [7:0]      ifu_arlen;
  logic            lsu_arvalid, lsu_arready, lsu_rvalid;
  logic [AW-1:0]   lsu_araddr, lsu_waddr;
  logic [1:0]      lsu_arsize;
  logic            lsu_wvalid, lsu_wready, lsu_bvalid;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_wstrb;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            mem_arvalid, mem_arready;
  logic [AW-1:0]   mem_araddr, mem_waddr;
  logic [7:0]      mem_arlen;
  logic [1:0]      mem_arsize;
  logic            mem_rvalid, mem_rlast, mem_rerr;
  logic [DW-1:0]   mem_rdata, mem_wdata;
  logic            mem_wvalid, mem_wready, mem_bvalid, mem_berr;
  logic [DW/8-1:0] mem_wstrb;

  ysyx_25040111_mem_bus_sched #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid),
    .lsu_wvalid(lsu_wvalid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_rerr(mem_rerr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_bvalid(mem_bvalid), .mem_berr(mem_berr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-beat observations captured by the memory driver.
  logic [DW-1:0] exp_data [0:15];
  logic [DW-1:0] obs_data [0:15];
  logic          obs_irv [0:15];
  logic          obs_lrv [0:15];
  logic          obs_rlast [0:15];
  logic          obs_err [0:15];
  logic          gap_bad;
  // Address-phase observations.
  logic          aph_ok;
  logic [AW-1:0] aph_addr;
  logic [7:0]    aph_len;
  logic [1:0]    aph_size;
  // Write-phase observations.
  logic          wph_ok, wph_b, wph_berr;
  int            wph_cycles;
  logic [AW-1:0] wph_addr;
  logic [DW-1:0] wph_data;
  logic [3:0]    wph_strb;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Accepts the read address after 'delay' stall cycles; a spurious rvalid
  // is offered in the first cycle and must not be forwarded.
  task automatic addr_phase(input int delay);
    aph_ok = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      mem_arready = (i == delay);
      mem_rvalid  = (i == 0);
      mem_rdata   = $urandom;
      #1;
      if (!mem_arvalid || ifu_rvalid || lsu_rvalid) aph_ok = 1'b0;
      if (i == 0) begin
        aph_addr = mem_araddr; aph_len = mem_arlen; aph_size = mem_arsize;
      end else if (mem_araddr !== aph_addr || mem_arlen !== aph_len || mem_arsize !== aph_size) begin
        aph_ok = 1'b0;
      end
      tick();
    end
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
  endtask

  // Supplies nb read beats with random gaps, recording what the DUT forwards.
  task automatic drive_beats(input int nb, input int rlast_at, input int err_at);
    int gaps;
    gap_bad = 1'b0;
    for (int b = 0; b < nb; b++) begin
      gaps = $urandom_range(0, 1);
      for (int g = 0; g < gaps; g++) begin
        mem_rvalid = 1'b0; mem_rlast = 1'b1;
        #1;
        if (ifu_rvalid || lsu_rvalid || ifu_rlast) gap_bad = 1'b1;
        tick();
      end
      exp_data[b] = $urandom;
      mem_rvalid = 1'b1; mem_rdata = exp_data[b];
      mem_rlast = (b == rlast_at); mem_rerr = (b == err_at);
      #1;
      obs_irv[b] = ifu_rvalid; obs_lrv[b] = lsu_rvalid; obs_rlast[b] = ifu_rlast;
      obs_err[b] = rsp_err;    obs_data[b] = rsp_data;
      tick();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rerr = 1'b0;
  endtask

  // Accepts the write after 'delay' stall cycles, then returns a response.
  task automatic write_phase(input int delay, input logic berr);
    int gaps;
    wph_ok = 1'b1; wph_cycles = 0;
    for (int i = 0; i <= delay; i++) begin
      mem_wready = (i == delay);
      mem_bvalid = (i == 0); mem_berr = 1'b1;
      #1;
      if (mem_wvalid) wph_cycles++;
      if (lsu_bvalid) wph_ok = 1'b0;
      if (i == 0) begin
        wph_addr = mem_waddr; wph_data = mem_wdata; wph_strb = mem_wstrb;
      end else if (mem_waddr !== wph_addr || mem_wdata !== wph_data || mem_wstrb !== wph_strb) begin
        wph_ok = 1'b0;
      end
      tick();
    end
    mem_wready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      #1;
      if (lsu_bvalid) wph_ok = 1'b0;
      tick();
    end
    mem_bvalid = 1'b1; mem_berr = berr;
    #1;
    wph_b = lsu_bvalid; wph_berr = rsp_err;
    tick();
    mem_bvalid = 1'b0; mem_berr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ifu_arvalid = 1'b1; lsu_wvalid = 1'b1; mem_rvalid = 1'b1; mem_bvalid = 1'b1;
    #1;
    n_cmp++;
    if ({ifu_arready, ifu_rvalid, ifu_rlast, lsu_arready, lsu_rvalid, lsu_wready, lsu_bvalid,
         rsp_data, rsp_err, mem_arvalid, mem_wvalid} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_during_reset: some output nonzero, required all 0");
    end
    tick();
    reset = 1'b0; ifu_arvalid = 1'b0; lsu_wvalid = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
    #1;
    n_cmp++;
    if ({ifu_arready, ifu_rvalid, ifu_rlast, lsu_arready, lsu_rvalid, lsu_wready, lsu_bvalid,
         rsp_data, rsp_err, mem_arvalid, mem_araddr, mem_arlen, mem_arsize,
         mem_wvalid, mem_waddr, mem_wdata, mem_wstrb} !== '0) begin
      n_bad++; $display("FAIL reset_outputs_after_reset: some output nonzero, required all 0");
    end
    tick();
  endtask

  task automatic test_ifu_burst();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd3;
    #1;
    n_cmp++;
    if ({ifu_arready, lsu_arready, lsu_wready} !== 3'b100) begin
      n_bad++; $display("FAIL ifu_grant: got %b required 100", {ifu_arready, lsu_arready, lsu_wready});
    end
    tick();
    ifu_arvalid = 1'b0; ifu_araddr = $urandom; ifu_arlen = 8'hff;
    addr_phase($urandom_range(0, 2));
    n_cmp++;
    if ({aph_ok, aph_addr, aph_len, aph_size} !== {1'b1, 32'h3000_0000, 8'd3, 2'd2}) begin
      n_bad++; $display("FAIL ifu_addr_phase: got ok=%b a=%h len=%0d size=%0d required 1 30000000 3 2",
                        aph_ok, aph_addr, aph_len, aph_size);
    end
    drive_beats(4, 3, -1);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if ({obs_irv[b], obs_lrv[b], obs_rlast[b], obs_err[b], obs_data[b]} !== {1'b1, 1'b0, b == 3, 1'b0, exp_data[b]}) begin
        n_bad++; $display("FAIL ifu_beat%0d: got rv=%b/%b last=%b err=%b d=%h required 1/0 %b 0 %h",
                          b, obs_irv[b], obs_lrv[b], obs_rlast[b], obs_err[b], obs_data[b], b == 3, exp_data[b]);
      end
    end
    n_cmp++;
    if (gap_bad !== 1'b0) begin n_bad++; $display("FAIL ifu_gap_forward: got 1 required 0"); end
    // Back in IDLE: spurious downstream responses must be ignored.
    mem_rvalid = 1'b1; mem_bvalid = 1'b1;
    #1;
    n_cmp++;
    if ({ifu_rvalid, lsu_rvalid, lsu_bvalid, mem_arvalid, mem_wvalid} !== 5'b0) begin
      n_bad++; $display("FAIL idle_spurious: got %b required 00000",
                        {ifu_rvalid, lsu_rvalid, lsu_bvalid, mem_arvalid, mem_wvalid});
    end
    tick();
    mem_rvalid = 1'b0; mem_bvalid = 1'b0;
    #1;
    n_cmp++;
    if ({mem_arvalid, mem_wvalid} !== 2'b00) begin
      n_bad++; $display("FAIL idle_stays: got %b required 00", {mem_arvalid, mem_wvalid});
    end
    tick();
  endtask

  task automatic test_tie();
    logic [AW-1:0] ia, la;
    logic [7:0]    il;
    logic [1:0]    ls;
    reset_dut();
    ia = $urandom; il = 8'($urandom_range(0, 3)); la = $urandom; ls = 2'($urandom_range(0, 2));
    ifu_arvalid = 1'b1; ifu_araddr = ia; ifu_arlen = il;
    lsu_arvalid = 1'b1; lsu_araddr = la; lsu_arsize = ls;
    #1;
    n_cmp++;
    if ({ifu_arready, lsu_arready} !== 2'b10) begin
      n_bad++; $display("FAIL tie_first_grant: got %b required 10", {ifu_arready, lsu_arready});
    end
    tick();
    ifu_arvalid = 1'b0;
    addr_phase($urandom_range(0, 1));
    n_cmp++;
    if ({aph_ok, aph_addr, aph_len, aph_size} !== {1'b1, ia, il, 2'd2}) begin
      n_bad++; $display("FAIL tie_ifu_addr: got ok=%b a=%h len=%0d size=%0d required 1 %h %0d 2",
                        aph_ok, aph_addr, aph_len, aph_size, ia, il);
    end
    drive_beats(int'(il) + 1, int'(il), -1);
    for (int b = 0; b <= int'(il); b++) begin
      n_cmp++;
      if ({obs_irv[b], obs_lrv[b], obs_rlast[b], obs_data[b]} !== {1'b1, 1'b0, b == int'(il), exp_data[b]}) begin
        n_bad++; $display("FAIL tie_ifu_beat%0d: got rv=%b/%b last=%b d=%h required 1/0 %b %h",
                          b, obs_irv[b], obs_lrv[b], obs_rlast[b], obs_data[b], b == int'(il), exp_data[b]);
      end
    end
    #1;
    n_cmp++;
    if (lsu_arready !== 1'b1) begin
      n_bad++; $display("FAIL tie_lsu_after_done: got lsu_arready=%b required 1", lsu_arready);
    end
    tick();
    lsu_arvalid = 1'b0;
    addr_phase($urandom_range(0, 1));
    n_cmp++;
    if ({aph_ok, aph_addr, aph_len, aph_size} !== {1'b1, la, 8'd0, ls}) begin
      n_bad++; $display("FAIL tie_lsu_addr: got ok=%b a=%h len=%0d size=%0d required 1 %h 0 %0d",
                        aph_ok, aph_addr, aph_len, aph_size, la, ls);
    end
    drive_beats(1, 0, -1);
    n_cmp++;
    if ({obs_irv[0], obs_lrv[0], obs_rlast[0], obs_err[0], obs_data[0]} !== {1'b0, 1'b1, 1'b0, 1'b0, exp_data[0]}) begin
      n_bad++; $display("FAIL tie_lsu_beat: got rv=%b/%b last=%b err=%b d=%h required 0/1 0 0 %h",
                        obs_irv[0], obs_lrv[0], obs_rlast[0], obs_err[0], obs_data[0], exp_data[0]);
    end
  endtask

  task automatic test_write();
    logic [AW-1:0] ra;
    ra = $urandom;
    lsu_wvalid = 1'b1; lsu_waddr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'h3;
    lsu_arvalid = 1'b1; lsu_araddr = ra; lsu_arsize = 2'd1;
    #1;
    n_cmp++;
    if ({lsu_wready, lsu_arready, ifu_arready} !== 3'b100) begin
      n_bad++; $display("FAIL write_wins: got %b required 100", {lsu_wready, lsu_arready, ifu_arready});
    end
    tick();
    lsu_wvalid = 1'b0; lsu_wdata = $urandom;
    write_phase(2, 1'b0);
    n_cmp++;
    if ({wph_ok, wph_cycles[3:0], wph_addr, wph_data, wph_strb} !== {1'b1, 4'd3, 32'h8000_0010, 32'hDEAD_BEEF, 4'h3}) begin
      n_bad++; $display("FAIL write_req: got ok=%b cyc=%0d a=%h d=%h s=%h required 1 3 80000010 deadbeef 3",
                        wph_ok, wph_cycles, wph_addr, wph_data, wph_strb);
    end
    n_cmp++;
    if ({wph_b, wph_berr} !== 2'b10) begin
      n_bad++; $display("FAIL write_rsp: got bvalid=%b err=%b required 1 0", wph_b, wph_berr);
    end
    // The held LSU read is served next.
    #1;
    n_cmp++;
    if (lsu_arready !== 1'b1) begin
      n_bad++; $display("FAIL write_then_read: got lsu_arready=%b required 1", lsu_arready);
    end
    tick();
    lsu_arvalid = 1'b0;
    addr_phase(0);
    drive_beats(1, 0, -1);
    n_cmp++;
    if ({aph_addr, aph_size, obs_lrv[0], obs_data[0]} !== {ra, 2'd1, 1'b1, exp_data[0]}) begin
      n_bad++; $display("FAIL write_then_read_data: got a=%h sz=%0d rv=%b d=%h required %h 1 1 %h",
                        aph_addr, aph_size, obs_lrv[0], obs_data[0], ra, exp_data[0]);
    end
  endtask

  task automatic test_rlast_err();
    int rl, ea;
    logic want_err;
    for (int v = 0; v < 2; v++) begin
      rl = (v == 0) ? 1 : -1;         // early rlast on beat 2, then missing rlast
      ea = (v == 0) ? -1 : $urandom_range(0, 2);
      ifu_arvalid = 1'b1; ifu_araddr = $urandom; ifu_arlen = 8'd3;
      tick();
      ifu_arvalid = 1'b0;
      addr_phase(0);
      drive_beats(4, rl, ea);
      for (int b = 0; b < 4; b++) begin
        want_err = (b == ea) || ((b == rl) != (b == 3));
        n_cmp++;
        if ({obs_irv[b], obs_rlast[b], obs_err[b], obs_data[b]} !== {1'b1, b == 3, want_err, exp_data[b]}) begin
          n_bad++; $display("FAIL rlast_err_v%0d_beat%0d: got rv=%b last=%b err=%b d=%h required 1 %b %b %h",
                            v, b, obs_irv[b], obs_rlast[b], obs_err[b], obs_data[b], b == 3, want_err, exp_data[b]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          want_lsu;
    logic [AW-1:0] ia, la;
    logic [7:0]    il;
    logic          lk, berr;
    logic [1:0]    ls;
    logic [DW-1:0] ld;
    logic [3:0]    lst;
    reset_dut();
    want_lsu = 1'b0;
    ia = $urandom; il = 8'($urandom_range(0, 3));
    lk = 1'b1; la = $urandom; ls = 2'($urandom_range(0, 2)); ld = $urandom; lst = 4'($urandom);
    for (int t = 0; t < 8; t++) begin
      ifu_arvalid = 1'b1; ifu_araddr = ia; ifu_arlen = il;
      lsu_wvalid = lk; lsu_arvalid = !lk; lsu_waddr = la; lsu_araddr = la;
      lsu_arsize = ls; lsu_wdata = ld; lsu_wstrb = lst;
      #1;
      n_cmp++;
      if ({ifu_arready, lsu_arready, lsu_wready} !== {!want_lsu, want_lsu && !lk, want_lsu && lk}) begin
        n_bad++; $display("FAIL b2b_grant%0d: got %b required %b", t, {ifu_arready, lsu_arready, lsu_wready},
                          {!want_lsu, want_lsu && !lk, want_lsu && lk});
      end
      tick();
      if (!want_lsu) begin
        addr_phase($urandom_range(0, 2));
        n_cmp++;
        if ({aph_ok, aph_addr, aph_len, aph_size} !== {1'b1, ia, il, 2'd2}) begin
          n_bad++; $display("FAIL b2b_ifu_addr%0d: got ok=%b a=%h len=%0d required 1 %h %0d", t, aph_ok, aph_addr, aph_len, ia, il);
        end
        drive_beats(int'(il) + 1, int'(il), -1);
        for (int b = 0; b <= int'(il); b++) begin
          n_cmp++;
          if ({obs_irv[b], obs_lrv[b], obs_rlast[b], obs_data[b]} !== {1'b1, 1'b0, b == int'(il), exp_data[b]}) begin
            n_bad++; $display("FAIL b2b_ifu_beat%0d_%0d: got rv=%b/%b last=%b d=%h required 1/0 %b %h",
                              t, b, obs_irv[b], obs_lrv[b], obs_rlast[b], obs_data[b], b == int'(il), exp_data[b]);
          end
        end
        ia = $urandom; il = 8'($urandom_range(0, 3));
      end else if (lk) begin
        berr = (t == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        write_phase($urandom_range(0, 2), berr);
        n_cmp++;
        if ({wph_ok, wph_addr, wph_data, wph_strb, wph_b, wph_berr} !== {1'b1, la, ld, lst, 1'b1, berr}) begin
          n_bad++; $display("FAIL b2b_write%0d: got ok=%b a=%h d=%h s=%h b=%b err=%b required 1 %h %h %h 1 %b",
                            t, wph_ok, wph_addr, wph_data, wph_strb, wph_b, wph_berr, la, ld, lst, berr);
        end
        lk = 1'($urandom_range(0, 1)); la = $urandom; ls = 2'($urandom_range(0, 2)); ld = $urandom; lst = 4'($urandom);
      end else begin
        addr_phase($urandom_range(0, 2));
        drive_beats(1, 0, -1);
        n_cmp++;
        if ({aph_ok, aph_addr, aph_len, aph_size, obs_lrv[0], obs_irv[0], obs_rlast[0], obs_data[0]} !==
            {1'b1, la, 8'd0, ls, 1'b1, 1'b0, 1'b0, exp_data[0]}) begin
          n_bad++; $display("FAIL b2b_lsu_read%0d: got a=%h len=%0d sz=%0d rv=%b/%b last=%b d=%h required %h 0 %0d 1/0 0 %h",
                            t, aph_addr, aph_len, aph_size, obs_lrv[0], obs_irv[0], obs_rlast[0], obs_data[0], la, ls, exp_data[0]);
        end
        lk = 1'($urandom_range(0, 1)); la = $urandom; ls = 2'($urandom_range(0, 2)); ld = $urandom; lst = 4'($urandom);
      end
      want_lsu = !want_lsu;
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_wvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ifu_arvalid = 1'b1; ifu_araddr = $urandom; ifu_arlen = 8'd3;
    tick();
    ifu_arvalid = 1'b0;
    addr_phase(0);
    mem_rvalid = 1'b1; mem_rdata = $urandom; mem_rlast = 1'b0;
    tick();
    reset = 1'b1; mem_rdata = $urandom;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom; mem_rlast = (c == 1);
      #1;
      n_cmp++;
      if ({ifu_rvalid, ifu_rlast, lsu_rvalid, lsu_bvalid, mem_arvalid, mem_wvalid, rsp_data} !== '0) begin
        n_bad++; $display("FAIL reset_mid_quiet%0d: got rv=%b last=%b lrv=%b ar=%b w=%b d=%h required all 0",
                          c, ifu_rvalid, ifu_rlast, lsu_rvalid, mem_arvalid, mem_wvalid, rsp_data);
      end
      tick();
    end
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    // IDLE with last_grant back at LSU: IFU must win a tie immediately.
    ifu_arvalid = 1'b1; ifu_arlen = 8'd0; lsu_arvalid = 1'b1; lsu_araddr = $urandom; lsu_arsize = 2'd0;
    #1;
    n_cmp++;
    if ({ifu_arready, lsu_arready} !== 2'b10) begin
      n_bad++; $display("FAIL reset_mid_regrant: got %b required 10", {ifu_arready, lsu_arready});
    end
    tick();
    ifu_arvalid = 1'b0;
    addr_phase(0);
    drive_beats(1, 0, -1);
    tick();
    lsu_arvalid = 1'b0;
    addr_phase(0);
    drive_beats(1, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = '0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_arsize = '0;
    lsu_wvalid = 1'b0; lsu_waddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; mem_rerr = 1'b0;
    mem_wready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0;
    tick();
    test_reset();
    test_ifu_burst();
    test_tie();
    test_write();
    test_rlast_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
